// File: rtl/robo_pkg.sv
// Shared constants for the robot sensor front end.
// Default filter timing plus sensor channel indices.
package robo_pkg;

  localparam int ROBO_TICK_DIV_DEF   = 4;
  localparam int ROBO_STABLE_CNT_DEF = 3;

  localparam int SENS_HEAD = 0;
  localparam int SENS_LEFT = 1;
  localparam int SENS_N    = 2;

endpackage

// File: rtl/robo_debounce_ch.sv
// One sensor channel: 2-flop synchronizer, run counter, output flop.
// Ports: clock, reset, tick (sample strobe), raw in; out level, flip strobe.
module robo_debounce_ch
  import robo_pkg::*;
#(
  parameter int STABLE_CNT = ROBO_STABLE_CNT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic out,
  output logic flip
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] cnt;

  assign s = sync[1];

  // High in the cycle whose edge will toggle out.
  assign flip = tick & (s != out) & (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      out  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (tick) begin
        if (s == out) begin
          cnt <= '0;
        end else if (flip) begin
          out <= s;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/robo_sensor_filter.sv
// Head/left obstacle sensor conditioner: shared sample prescaler,
// two debounced channels, and a pulse on any output toggle.
module robo_sensor_filter
  import robo_pkg::*;
#(
  parameter int TICK_DIV   = ROBO_TICK_DIV_DEF,
  parameter int STABLE_CNT = ROBO_STABLE_CNT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic head_raw,
  input  logic left_raw,
  output logic head,
  output logic left,
  output logic changed
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]     pre;
  logic              tick;
  logic [SENS_N-1:0] raw_v;
  logic [SENS_N-1:0] out_v;
  logic [SENS_N-1:0] flip_v;

  assign tick = (pre == PMAX);

  assign raw_v[SENS_HEAD] = head_raw;
  assign raw_v[SENS_LEFT] = left_raw;
  assign head = out_v[SENS_HEAD];
  assign left = out_v[SENS_LEFT];

  robo_debounce_ch #(
    .STABLE_CNT(STABLE_CNT)
  ) u_head (
    .clock(clock),
    .reset(reset),
    .tick (tick),
    .raw  (raw_v[SENS_HEAD]),
    .out  (out_v[SENS_HEAD]),
    .flip (flip_v[SENS_HEAD])
  );

  robo_debounce_ch #(
    .STABLE_CNT(STABLE_CNT)
  ) u_left (
    .clock(clock),
    .reset(reset),
    .tick (tick),
    .raw  (raw_v[SENS_LEFT]),
    .out  (out_v[SENS_LEFT]),
    .flip (flip_v[SENS_LEFT])
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pre     <= '0;
      changed <= 1'b0;
    end else begin
      pre     <= tick ? '0 : pre + 1'b1;
      // OR of both strobes: simultaneous toggles yield one pulse.
      changed <= |flip_v;
    end
  end

endmodule

// File: tb/tb_robo_sensor_filter.sv
// Directed bench for robo_sensor_filter (default and 1/1 timing).
// Inputs driven and outputs sampled on the falling edge.
module tb_robo_sensor_filter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic head_raw = 1'b0;
  logic left_raw = 1'b0;
  logic head, left, changed;
  logic h2_raw = 1'b0;
  logic l2_raw = 1'b0;
  logic head2, left2, changed2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  robo_sensor_filter dut (
    .clock   (clock),
    .reset   (reset),
    .head_raw(head_raw),
    .left_raw(left_raw),
    .head    (head),
    .left    (left),
    .changed (changed)
  );

  robo_sensor_filter #(
    .TICK_DIV  (1),
    .STABLE_CNT(1)
  ) dut_fast (
    .clock   (clock),
    .reset   (reset),
    .head_raw(h2_raw),
    .left_raw(l2_raw),
    .head    (head2),
    .left    (left2),
    .changed (changed2)
  );

  typedef struct {
    logic h;
    logic l;
    int   n;
    logic eh;
    logic el;
    int   ec;
  } seg_t;

  seg_t tbl [10];

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Leaves reset low at a falling edge; the
  // caller drives raws there, ahead of edge e1.
  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    head_raw = 1'b0;
    left_raw = 1'b0;
    h2_raw   = 1'b0;
    l2_raw   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int lat, pulses, bad, rh, rl;
    logic [39:0] pat_h, pat_l;
    logic hist_h [0:41];
    logic hist_l [0:41];
    logic eh, el, peh, pel;

    //        h   l   n  eh  el  ec
    tbl[0] = '{1, 0, 14, 1, 0, 1};
    tbl[1] = '{1, 1,  8, 1, 0, 0};
    tbl[2] = '{1, 0,  8, 1, 0, 0};
    tbl[3] = '{0, 1, 14, 0, 1, 1};
    tbl[4] = '{0, 1,  2, 0, 1, 0};
    tbl[5] = '{1, 1,  2, 0, 1, 0};
    tbl[6] = '{0, 1,  2, 0, 1, 0};
    tbl[7] = '{1, 1,  2, 0, 1, 0};
    tbl[8] = '{0, 1,  2, 0, 1, 0};
    tbl[9] = '{1, 1, 14, 1, 1, 1};

    // Reset state
    do_reset();
    chk("rst_head", int'(head), 0);
    chk("rst_left", int'(left), 0);
    chk("rst_chg", int'(changed), 0);

    // Table: segments run back to back
    for (int i = 0; i < 10; i++) begin
      head_raw = tbl[i].h;
      left_raw = tbl[i].l;
      pulses = 0;
      for (int c = 0; c < tbl[i].n; c++) begin
        @(negedge clock);
        if (changed) pulses++;
      end
      chk($sformatf("seg%0d_head", i),
          int'(head), int'(tbl[i].eh));
      chk($sformatf("seg%0d_left", i),
          int'(left), int'(tbl[i].el));
      chk($sformatf("seg%0d_chg", i),
          pulses, tbl[i].ec);
    end

    // Step on head: latency and one pulse
    do_reset();
    head_raw = 1'b1;
    lat = 0;
    pulses = 0;
    while (!head && lat < 30) begin
      @(negedge clock);
      lat++;
      if (changed) pulses++;
    end
    chk("t1_lat_range",
        int'(lat >= 11 && lat <= 14), 1);
    chk("t1_lat", lat, 12);
    repeat (10) begin
      @(negedge clock);
      if (changed) pulses++;
    end
    chk("t1_pulses", pulses, 1);
    chk("t1_left", int'(left), 0);

    // 8-cycle left pulse at each prescaler phase
    for (int p = 0; p < 4; p++) begin
      do_reset();
      bad = 0;
      repeat (p) @(negedge clock);
      left_raw = 1'b1;
      repeat (8) begin
        @(negedge clock);
        if (left || changed) bad++;
      end
      left_raw = 1'b0;
      repeat (16) begin
        @(negedge clock);
        if (left || changed) bad++;
      end
      chk($sformatf("t2_glitch_p%0d", p), bad, 0);
    end

    // Simultaneous step on both channels
    do_reset();
    head_raw = 1'b1;
    left_raw = 1'b1;
    rh = -1;
    rl = -1;
    pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (head && rh < 0) rh = c;
      if (left && rl < 0) rl = c;
      if (changed) pulses++;
    end
    chk("t4_head_edge", rh, 12);
    chk("t4_same_edge", rl, rh);
    chk("t4_pulses", pulses, 1);

    // Reset while the head run count is at 2
    do_reset();
    head_raw = 1'b1;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_head_in_rst", int'(head), 0);
    reset = 1'b0;
    lat = 0;
    while (!head && lat < 30) begin
      @(negedge clock);
      lat++;
    end
    chk("t5_lat_range",
        int'(lat >= 12 && lat <= 15), 1);
    chk("t5_lat", lat, 12);

    // 1/1 timing: output is raw delayed 3 edges
    pat_h = 40'hC3_5A_F0_96_1E;
    pat_l = 40'h0F_A5_33_CC_71;
    do_reset();
    for (int k = 0; k < 42; k++) begin
      hist_h[k] = 1'b0;
      hist_l[k] = 1'b0;
    end
    hist_h[1] = pat_h[0];
    hist_l[1] = pat_l[0];
    h2_raw = hist_h[1];
    l2_raw = hist_l[1];
    peh = 1'b0;
    pel = 1'b0;
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      eh = (k >= 3) ? hist_h[k-2] : 1'b0;
      el = (k >= 3) ? hist_l[k-2] : 1'b0;
      if (head2 !== eh || left2 !== el ||
          changed2 !== ((eh != peh) || (el != pel)))
      begin
        bad++;
        $display("FAIL t6_k%0d: got h%0b l%0b c%0b expected h%0b l%0b c%0b",
                 k, head2, left2, changed2,
                 eh, el, (eh != peh) || (el != pel));
      end
      peh = eh;
      pel = el;
      if (k < 40) begin
        hist_h[k+1] = pat_h[k];
        hist_l[k+1] = pat_l[k];
        h2_raw = hist_h[k+1];
        l2_raw = hist_l[k+1];
      end
    end
    chk("t6_fast_path", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
